qpu_exu_alu_mpath: RTL and testbench
====================================

// Module: qpu_exu_alu_mpath
// PURPOSE
//  Pipelined, multi-requestor ALU datapath for the QPU execute unit.
//  Arbitrates NREQ requestors (ALU/BJP/LSU/QIU/...) round-robin; one op accepted per cycle.
//  Computes arith/logic/shift/compare in a 2-stage pipe; returns result tagged with requestor id.
//  Valid/ready on every port; output backpressure stalls the pipe without losing data.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, power of 2)
//  NREQ   4   number of requestors (>=1)
//  IDW    2   requestor id width, = max(1,$clog2(NREQ))
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-high
//  flush      in   1          kill all in-flight ops
//  req_valid  in   NREQ       request valid, bit i = requestor i
//  req_ready  out  NREQ       request accepted (one-hot or zero)
//  req_opc    in   NREQ*4     opcode, slice [4i+3:4i]
//  req_op1    in   NREQ*XLEN  operand 1, slice [XLEN*i+:XLEN]
//  req_op2    in   NREQ*XLEN  operand 2
//  rsp_valid  out  1          result valid
//  rsp_ready  in   1          consumer ready
//  rsp_id     out  IDW        requestor index of result
//  rsp_res    out  XLEN       result
//  rsp_cmp    out  1          compare outcome (opc 8..15), else 0
// BEHAVIOUR
//  Opcodes: 0 ADD,1 SUB,2 XOR,3 OR,4 AND,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,
//   10 EQ,11 NE,12 LT,13 GE,14 LTU,15 GEU.
//  Shifts: amount = op2[$clog2(XLEN)-1:0]; upper op2 bits ignored.
//  ADD/SUB wrap mod 2^XLEN. Signed compares via single XLEN+1 sign-extended subtractor
//   (op1 + ~op2 + 1, bit XLEN = lt); unsigned via zero-extension; EQ/NE via XOR-reduce.
//  Opc 8..15: rsp_res = {XLEN-1 zeros, rsp_cmp}. Opc 0..7: rsp_cmp = 0.
//  Pipe: S1 = registered winning request (opc, op1, op2, id); S2 = registered result.
//  s2_adv = ~s2_valid | rsp_ready;  s1_adv = s1_valid & s2_adv;
//  accept = |req_valid & (~s1_valid | s2_adv) & ~flush.
//  Latency: accept in cycle N -> rsp_valid in N+2 if rsp_ready held high. Throughput 1/cycle.
//  Arbiter: round-robin; priority starts at (last_granted+1) mod NREQ; pointer updates only
//   on accept. Reset pointer: requestor 0 highest priority.
//  req_ready[i] = accept & grant[i]; combinational from req_valid (no valid->ready loop
//   on same requestor's valid beyond grant). req_ready never asserts for an invalid requestor.
//  rsp_valid low + rsp_ready low: S2 empty, S1 advances. rsp_valid high + rsp_ready low: rsp_*
//   held stable, S1 holds, accept only if S1 empty.
//  flush: S1, S2 valid cleared next cycle; no accept in the flush cycle; arbiter pointer unchanged.
//   flush and rsp_ready same cycle: result dropped (consumer must ignore).
//  Reset: rsp_valid=0, rsp_id=0, rsp_res=0, rsp_cmp=0, S1/S2 valid=0, req_ready=0 during rst.
//   Reset mid-operation discards all in-flight ops.
//  Data regs update only when their stage loads; invalid stages hold stale data (no gating).
// STRUCTURE
//  Package qpu_alu_pkg: opcode localparams (QPU_ALU_OPC_*), opcode width 4, helper fn
//   is_cmp(opc). Shared with decoder/BJP.
//  Sub-module qpu_rr_arbiter #(N): req vector, accept strobe -> one-hot grant, encoded id.
//  Compute logic inline between S1 and S2 (adder, xorer, shifter, compare mux).
// TESTING
//  Reset: rst high 2 cycles with all req_valid=1 -> rsp_valid=0, req_ready=0, outputs 0.
//  Ops, XLEN=32: ADD 0xFFFFFFFF+1 -> res 0; SUB 5-7 -> 0xFFFFFFFE; SRA 0x80000000>>4 ->
//   0xF8000000; SLL 1<<33 -> 2; SLTU 1,0xFFFFFFFF -> res 1; LT 1,0xFFFFFFFF -> cmp 0; GEU -> 0.
//  Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,... ids in order,
//   one result per cycle after 2-cycle fill.
//  Backpressure: rsp_ready=0 for 5 cycles with 4 ops offered -> exactly 2 accepted, rsp_* stable;
//   release -> both results in order, no loss/duplication.
//  Flush: accept ops A (N), B (N+1), flush at N+1 -> neither A nor B responds; req_ready=0 at N+1.
//  Random: constrained-random opcodes/operands/valid/ready vs. reference model; scoreboard per id.

Source files
------------

// File: rtl/qpu_alu_pkg.sv
// QPU ALU shared definitions: opcode encodings and helpers.
// Used by the ALU datapath, the decoder and the BJP unit.
package qpu_alu_pkg;

   localparam int QPU_ALU_OPC_W = 4;

   typedef logic [QPU_ALU_OPC_W-1:0] qpu_alu_opc_t;

   localparam qpu_alu_opc_t QPU_ALU_OPC_ADD  = 4'd0;
   localparam qpu_alu_opc_t QPU_ALU_OPC_SUB  = 4'd1;
   localparam qpu_alu_opc_t QPU_ALU_OPC_XOR  = 4'd2;
   localparam qpu_alu_opc_t QPU_ALU_OPC_OR   = 4'd3;
   localparam qpu_alu_opc_t QPU_ALU_OPC_AND  = 4'd4;
   localparam qpu_alu_opc_t QPU_ALU_OPC_SLL  = 4'd5;
   localparam qpu_alu_opc_t QPU_ALU_OPC_SRL  = 4'd6;
   localparam qpu_alu_opc_t QPU_ALU_OPC_SRA  = 4'd7;
   localparam qpu_alu_opc_t QPU_ALU_OPC_SLT  = 4'd8;
   localparam qpu_alu_opc_t QPU_ALU_OPC_SLTU = 4'd9;
   localparam qpu_alu_opc_t QPU_ALU_OPC_EQ   = 4'd10;
   localparam qpu_alu_opc_t QPU_ALU_OPC_NE   = 4'd11;
   localparam qpu_alu_opc_t QPU_ALU_OPC_LT   = 4'd12;
   localparam qpu_alu_opc_t QPU_ALU_OPC_GE   = 4'd13;
   localparam qpu_alu_opc_t QPU_ALU_OPC_LTU  = 4'd14;
   localparam qpu_alu_opc_t QPU_ALU_OPC_GEU  = 4'd15;

   // Compare ops occupy the upper half of the opcode space.
   function automatic logic is_cmp(qpu_alu_opc_t opc);
      return opc[3];
   endfunction

   function automatic logic is_signed_cmp(qpu_alu_opc_t opc);
      return (opc == QPU_ALU_OPC_SLT) ||
             (opc == QPU_ALU_OPC_LT)  ||
             (opc == QPU_ALU_OPC_GE);
   endfunction

endpackage

// File: rtl/qpu_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded id.
// Priority pointer advances past the winner only on accept.
module qpu_rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_i,
   input  logic           accept_i,
   output logic [N-1:0]   gnt_o,
   output logic [IDW-1:0] gnt_id_o
);

   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_d;

   // Scan from the priority pointer, wrapping, and grant the first request.
   always_comb begin
      int  idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      gnt_o    = '0;
      gnt_id_o = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req_i[idx]) begin
            found       = 1'b1;
            gnt_o[idx]  = 1'b1;
            gnt_id_o    = IDW'(idx);
         end
      end
   end

   // Next priority sits just after the requestor that was accepted.
   always_comb begin
      int nxt;
      nxt   = int'(gnt_id_o) + 1;
      if (nxt >= N) nxt = 0;
      ptr_d = ptr_q;
      if (accept_i) ptr_d = IDW'(nxt);
   end

   // Pointer register; requestor 0 has top priority out of reset.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/qpu_exu_alu_mpath.sv
// QPU execute-unit ALU datapath: round-robin front end,
// S1 operand register, inline compute, S2 result register.
module qpu_exu_alu_mpath
   import qpu_alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREQ = 4,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*4-1:0]      req_opc,
   input  logic [NREQ*XLEN-1:0]   req_op1,
   input  logic [NREQ*XLEN-1:0]   req_op2,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [XLEN-1:0]        rsp_res,
   output logic                   rsp_cmp
);

   localparam int SHW = $clog2(XLEN);

   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_id;
   logic            accept;
   logic            s1_adv;
   logic            s2_adv;

   qpu_alu_opc_t    win_opc;
   logic [XLEN-1:0] win_op1;
   logic [XLEN-1:0] win_op2;

   logic            s1_vld_q, s1_vld_d;
   qpu_alu_opc_t    s1_opc_q, s1_opc_d;
   logic [XLEN-1:0] s1_op1_q, s1_op1_d;
   logic [XLEN-1:0] s1_op2_q, s1_op2_d;
   logic [IDW-1:0]  s1_id_q,  s1_id_d;

   logic            s2_vld_q, s2_vld_d;
   logic [XLEN-1:0] s2_res_q, s2_res_d;
   logic            s2_cmp_q, s2_cmp_d;
   logic [IDW-1:0]  s2_id_q,  s2_id_d;

   logic [XLEN-1:0] alu_res;
   logic            alu_cmp;

   assign s2_adv = ~s2_vld_q | rsp_ready;
   assign s1_adv = s1_vld_q & s2_adv;
   assign accept = (|req_valid) & (~s1_vld_q | s2_adv)
                 & ~flush & ~rst;

   assign req_ready = gnt & {NREQ{accept}};

   qpu_rr_arbiter #(
      .N   (NREQ),
      .IDW (IDW)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req_valid),
      .accept_i (accept),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   // Select the winning requestor's fields with a one-hot AND-OR mux.
   always_comb begin
      win_opc = '0;
      win_op1 = '0;
      win_op2 = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            win_opc = win_opc | req_opc[4*i +: 4];
            win_op1 = win_op1 | req_op1[XLEN*i +: XLEN];
            win_op2 = win_op2 | req_op2[XLEN*i +: XLEN];
         end
      end
   end

   // S1 next state: load on accept, drain on advance, kill on flush.
   always_comb begin
      s1_opc_d = s1_opc_q;
      s1_op1_d = s1_op1_q;
      s1_op2_d = s1_op2_q;
      s1_id_d  = s1_id_q;
      if (accept) begin
         s1_opc_d = win_opc;
         s1_op1_d = win_op1;
         s1_op2_d = win_op2;
         s1_id_d  = gnt_id;
      end
      if (flush)       s1_vld_d = 1'b0;
      else if (accept) s1_vld_d = 1'b1;
      else if (s1_adv) s1_vld_d = 1'b0;
      else             s1_vld_d = s1_vld_q;
   end

   // Compute: one shared XLEN+1 adder serves ADD, SUB and magnitude compares.
   always_comb begin
      logic            sgn;
      logic            do_sub;
      logic [XLEN:0]   add_a;
      logic [XLEN:0]   add_b;
      logic [XLEN:0]   sum;
      logic            lt;
      logic            eq;
      logic [SHW-1:0]  shamt;

      sgn    = is_signed_cmp(s1_opc_q);
      do_sub = (s1_opc_q != QPU_ALU_OPC_ADD);
      add_a  = {sgn & s1_op1_q[XLEN-1], s1_op1_q};
      add_b  = {sgn & s1_op2_q[XLEN-1], s1_op2_q};
      if (do_sub) add_b = ~add_b;
      sum    = add_a + add_b + {{XLEN{1'b0}}, do_sub};
      lt     = sum[XLEN];
      eq     = ~|(s1_op1_q ^ s1_op2_q);
      shamt  = s1_op2_q[SHW-1:0];

      alu_res = '0;
      alu_cmp = 1'b0;
      unique case (s1_opc_q)
         QPU_ALU_OPC_ADD,
         QPU_ALU_OPC_SUB:  alu_res = sum[XLEN-1:0];
         QPU_ALU_OPC_XOR:  alu_res = s1_op1_q ^ s1_op2_q;
         QPU_ALU_OPC_OR:   alu_res = s1_op1_q | s1_op2_q;
         QPU_ALU_OPC_AND:  alu_res = s1_op1_q & s1_op2_q;
         QPU_ALU_OPC_SLL:  alu_res = s1_op1_q << shamt;
         QPU_ALU_OPC_SRL:  alu_res = s1_op1_q >> shamt;
         QPU_ALU_OPC_SRA:  alu_res = $signed(s1_op1_q) >>> shamt;
         QPU_ALU_OPC_SLT,
         QPU_ALU_OPC_SLTU,
         QPU_ALU_OPC_LT,
         QPU_ALU_OPC_LTU:  alu_cmp = lt;
         QPU_ALU_OPC_GE,
         QPU_ALU_OPC_GEU:  alu_cmp = ~lt;
         QPU_ALU_OPC_EQ:   alu_cmp = eq;
         QPU_ALU_OPC_NE:   alu_cmp = ~eq;
         default:          alu_res = '0;
      endcase
      if (is_cmp(s1_opc_q)) alu_res = {{(XLEN-1){1'b0}}, alu_cmp};
   end

   // S2 next state: capture result when S1 advances, drop when consumed.
   always_comb begin
      s2_res_d = s2_res_q;
      s2_cmp_d = s2_cmp_q;
      s2_id_d  = s2_id_q;
      if (s1_adv) begin
         s2_res_d = alu_res;
         s2_cmp_d = alu_cmp;
         s2_id_d  = s1_id_q;
      end
      if (flush)          s2_vld_d = 1'b0;
      else if (s1_adv)    s2_vld_d = 1'b1;
      else if (rsp_ready) s2_vld_d = 1'b0;
      else                s2_vld_d = s2_vld_q;
   end

   // Pipeline registers; reset clears valids and the visible result.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_opc_q <= '0;
         s1_op1_q <= '0;
         s1_op2_q <= '0;
         s1_id_q  <= '0;
         s2_vld_q <= 1'b0;
         s2_res_q <= '0;
         s2_cmp_q <= 1'b0;
         s2_id_q  <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_opc_q <= s1_opc_d;
         s1_op1_q <= s1_op1_d;
         s1_op2_q <= s1_op2_d;
         s1_id_q  <= s1_id_d;
         s2_vld_q <= s2_vld_d;
         s2_res_q <= s2_res_d;
         s2_cmp_q <= s2_cmp_d;
         s2_id_q  <= s2_id_d;
      end
   end

   assign rsp_valid = s2_vld_q;
   assign rsp_res   = s2_res_q;
   assign rsp_cmp   = s2_cmp_q;
   assign rsp_id    = s2_id_q;

endmodule

// File: tb/tb_qpu_exu_alu_mpath.sv
// Bench for qpu_exu_alu_mpath: behavioural queue model with a
// per-cycle compare, plus directed literal cases.
module tb_qpu_exu_alu_mpath;

   localparam int XLEN = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 flush = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*4-1:0]    req_opc = '0;
   logic [NREQ*XLEN-1:0] req_op1 = '0;
   logic [NREQ*XLEN-1:0] req_op2 = '0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b1;
   logic [IDW-1:0]       rsp_id;
   logic [XLEN-1:0]      rsp_res;
   logic                 rsp_cmp;

   int n_cmp = 0;
   int n_err = 0;

   qpu_exu_alu_mpath #(
      .XLEN (XLEN),
      .NREQ (NREQ),
      .IDW  (IDW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_opc   (req_opc),
      .req_op1   (req_op1),
      .req_op2   (req_op2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_res   (rsp_res),
      .rsp_cmp   (rsp_cmp)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference semantics: {cmp, res}
   function automatic logic [32:0] ref_alu(int opc,
                                           logic [31:0] a,
                                           logic [31:0] b);
      logic [31:0] r;
      logic        c;
      r = 0;
      c = 0;
      case (opc)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a ^ b;
         3:  r = a | b;
         4:  r = a & b;
         5:  r = a << b[4:0];
         6:  r = a >> b[4:0];
         7:  r = $signed(a) >>> b[4:0];
         8, 12: c = $signed(a) < $signed(b);
         9, 14: c = a < b;
         10: c = (a == b);
         11: c = (a != b);
         13: c = $signed(a) >= $signed(b);
         15: c = a >= b;
         default: r = 0;
      endcase
      if (opc >= 8) r = {31'd0, c};
      return {c, r};
   endfunction

   // Model state: in-order queue of expected responses with their age.
   int          m_ptr = 0;
   int          q_id[$];
   logic [32:0] q_val[$];
   int          q_age[$];

   bit          p_rst = 1'b1;
   bit          p_flush = 1'b0;
   bit          p_pop = 1'b0;
   bit          p_acc = 1'b0;
   int          p_g = 0;
   logic [32:0] p_val = '0;

   int hs_cnt = 0;
   int acc_cnt = 0;
   int got_ids[$];

   always @(negedge clk) begin
      bit exp_v;
      int g;
      logic [NREQ-1:0] exp_rdy;
      p_rst   = rst;
      p_flush = flush;
      p_pop   = 1'b0;
      p_acc   = 1'b0;
      if (rst) begin
         chk("rst_req_ready", req_ready, 0);
      end else begin
         exp_v = (q_id.size() > 0) && (q_age[0] >= 2);
         chk("rsp_valid", rsp_valid, exp_v);
         if (exp_v) begin
            chk("rsp_id", rsp_id, q_id[0]);
            chk("rsp_res", rsp_res, q_val[0][31:0]);
            chk("rsp_cmp", rsp_cmp, q_val[0][32]);
            p_pop = rsp_ready;
         end
         if (rsp_valid && rsp_ready && !flush) begin
            hs_cnt++;
            got_ids.push_back(int'(rsp_id));
         end
         g = -1;
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && req_valid[(m_ptr + k) % NREQ])
               g = (m_ptr + k) % NREQ;
         p_acc = (g >= 0) && !flush &&
                 (q_id.size() < 2 || rsp_ready);
         exp_rdy = p_acc ? NREQ'(1 << g) : '0;
         chk("req_ready", req_ready, exp_rdy);
         if (|req_ready) acc_cnt++;
         if (p_acc) begin
            p_g   = g;
            p_val = ref_alu(int'(req_opc[4*g +: 4]),
                            req_op1[XLEN*g +: XLEN],
                            req_op2[XLEN*g +: XLEN]);
         end
      end
   end

   always @(posedge clk) begin
      if (p_rst || p_flush) begin
         q_id.delete();
         q_val.delete();
         q_age.delete();
         if (p_rst) m_ptr = 0;
      end else begin
         if (p_pop) begin
            void'(q_id.pop_front());
            void'(q_val.pop_front());
            void'(q_age.pop_front());
         end
         if (p_acc) begin
            q_id.push_back(p_g);
            q_val.push_back(p_val);
            q_age.push_back(0);
            m_ptr = (p_g + 1) % NREQ;
         end
         foreach (q_age[i]) q_age[i]++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_res", rsp_res, 0);
      chk("rst_rsp_cmp", rsp_cmp, 0);
      step();
      rst       = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
   endtask

   task automatic run_one(string nm, int id, int opc,
                          logic [31:0] a, logic [31:0] b,
                          logic [31:0] er, logic ec);
      bit got;
      step();
      req_valid            = NREQ'(1 << id);
      req_opc[4*id +: 4]   = 4'(opc);
      req_op1[32*id +: 32] = a;
      req_op2[32*id +: 32] = b;
      got = 0;
      for (int t = 0; t < 8 && !got; t++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1;
      end
      chk({nm, "_accept"}, got, 1);
      step();
      req_valid = '0;
      got = 0;
      for (int t = 0; t < 8 && !got; t++) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
      end
      chk({nm, "_rsp"}, got, 1);
      chk({nm, "_id"}, rsp_id, id);
      chk({nm, "_res"}, rsp_res, er);
      chk({nm, "_cmp"}, rsp_cmp, ec);
   endtask

   initial begin
      logic [31:0] spec_v [0:5];
      spec_v[0] = 32'h0;
      spec_v[1] = 32'hFFFFFFFF;
      spec_v[2] = 32'h80000000;
      spec_v[3] = 32'h7FFFFFFF;
      spec_v[4] = 32'h1;
      spec_v[5] = 32'h21;

      // Pin the reference model against hand results.
      chk("pin_add", ref_alu(0, 32'hFFFFFFFF, 32'h1), 33'h0);
      chk("pin_sub", ref_alu(1, 32'h5, 32'h7), 33'h0FFFFFFFE);
      chk("pin_sra", ref_alu(7, 32'h80000000, 32'h4), 33'h0F8000000);
      chk("pin_lt", ref_alu(12, 32'h1, 32'hFFFFFFFF), 33'h0);
      chk("pin_sltu", ref_alu(9, 32'h1, 32'hFFFFFFFF), 33'h100000001);

      do_reset();

      run_one("add",  0, 0,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
      run_one("sub",  1, 1,  32'h5, 32'h7, 32'hFFFFFFFE, 1'b0);
      run_one("sra",  2, 7,  32'h80000000, 32'h4, 32'hF8000000, 1'b0);
      run_one("srl",  3, 6,  32'h80000000, 32'h4, 32'h08000000, 1'b0);
      run_one("sll",  0, 5,  32'h1, 32'h21, 32'h2, 1'b0);
      run_one("sltu", 1, 9,  32'h1, 32'hFFFFFFFF, 32'h1, 1'b1);
      run_one("lt",   2, 12, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0);
      run_one("geu",  3, 15, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0);
      run_one("ge",   0, 13, 32'h1, 32'hFFFFFFFF, 32'h1, 1'b1);
      run_one("eq",   1, 10, 32'hA5A5, 32'hA5A5, 32'h1, 1'b1);
      run_one("xor",  2, 2,  32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0);

      // Fairness: everybody valid, consumer always ready.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         req_opc[4*i +: 4]    = 4'd0;
         req_op1[32*i +: 32]  = 32'(i);
         req_op2[32*i +: 32]  = 32'h0;
      end
      hs_cnt = 0;
      got_ids.delete();
      req_valid = '1;
      repeat (10) step();
      req_valid = '0;
      repeat (4) step();
      chk("fair_count", hs_cnt, 10);
      for (int k = 0; k < 8; k++)
         chk("fair_order", (k < got_ids.size()) ? got_ids[k] : -1, k % 4);

      // Backpressure: stalled consumer admits exactly two ops.
      do_reset();
      rsp_ready = 1'b0;
      acc_cnt   = 0;
      hs_cnt    = 0;
      got_ids.delete();
      req_valid = '1;
      repeat (5) step();
      req_valid = '0;
      chk("bp_accepted", acc_cnt, 2);
      chk("bp_no_rsp", hs_cnt, 0);
      rsp_ready = 1'b1;
      repeat (4) step();
      chk("bp_drained", hs_cnt, 2);
      chk("bp_first", (got_ids.size() > 0) ? got_ids[0] : -1, 0);
      chk("bp_second", (got_ids.size() > 1) ? got_ids[1] : -1, 1);

      // Flush right behind an accept kills it and blocks the next.
      do_reset();
      hs_cnt = 0;
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0010;
      flush     = 1'b1;
      @(negedge clk);
      chk("flush_ready", req_ready, 0);
      step();
      flush     = 1'b0;
      req_valid = '0;
      repeat (5) step();
      chk("flush_no_rsp", hs_cnt, 0);

      // Random traffic checked by the model.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            req_opc[4*i +: 4] = 4'($urandom_range(0, 15));
            req_op1[32*i +: 32] = ($urandom_range(0, 2) == 0) ?
               spec_v[$urandom_range(0, 5)] : $urandom;
            req_op2[32*i +: 32] = ($urandom_range(0, 2) == 0) ?
               spec_v[$urandom_range(0, 5)] : $urandom;
         end
         req_valid = NREQ'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         step();
      end
      req_valid = '0;
      flush     = 1'b0;
      rsp_ready = 1'b1;
      repeat (6) step();
      chk("drain_empty", rsp_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
